// File: rtl/branch_ctrl.sv
// branch_ctrl
//   Next-PC control for a 6-bit program counter. Each cycle it decides whether
//   the PC loads a redirect target (jump, taken branch, call, return) or keeps
//   incrementing. It keeps the return addresses in an internal stack and raises
//   a one-cycle flush to the decoder after every redirect.
//
// Parameters
//   DEPTH    return-stack entries, 1..15
// Ports
//   clk      clock
//   rst_n    synchronous active-low reset
//   pc_cur   current PC value
//   jmp      unconditional jump to target
//   br       conditional branch to target, taken when cond=1
//   cond     branch condition
//   call     push pc_cur+1, jump to target
//   ret      pop return address, jump to it
//   target   jump/branch/call destination
//   clr_err  clears sticky ovf/unf (a same-cycle error event wins)
//   pc_next  value for the PC load port (combinational)
//   pc_we    PC load enable (combinational)
//   flush    registered copy of the previous cycle's pc_we
//   depth    stack occupancy 0..DEPTH
//   ovf      sticky: call with stack full
//   unf      sticky: ret with stack empty
module branch_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] pc_cur,
  input  logic       jmp,
  input  logic       br,
  input  logic       cond,
  input  logic       call,
  input  logic       ret,
  input  logic [5:0] target,
  input  logic       clr_err,
  output logic [5:0] pc_next,
  output logic       pc_we,
  output logic       flush,
  output logic [3:0] depth,
  output logic       ovf,
  output logic       unf
);

  localparam logic [3:0] DMAX = 4'(DEPTH);

  // Storage is sized to the full 4-bit index range so depth can address it
  // directly; entries at or above DEPTH are never written.
  logic [5:0] stk [16];

  logic [5:0] ret_addr;
  logic [5:0] top;
  logic       push, pop;
  logic       ovf_ev, unf_ev;

  assign ret_addr = pc_cur + 6'd1;   // wraps 63 -> 0
  assign top      = stk[depth - 4'd1];

  // Request decode, priority ret > call > jmp > br.
  always_comb begin
    pc_next = '0;
    pc_we   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_ev  = 1'b0;
    unf_ev  = 1'b0;
    if (ret) begin
      if (depth != 4'd0) begin
        pc_next = top;
        pc_we   = 1'b1;
        pop     = 1'b1;
      end else begin
        unf_ev  = 1'b1;
      end
    end else if (call) begin
      // A full stack still redirects; only the push is dropped.
      pc_next = target;
      pc_we   = 1'b1;
      if (depth < DMAX) push   = 1'b1;
      else              ovf_ev = 1'b1;
    end else if (jmp) begin
      pc_next = target;
      pc_we   = 1'b1;
    end else if (br && cond) begin
      pc_next = target;
      pc_we   = 1'b1;
    end
  end

  // Stack entries carry no reset; pushes are held off while in reset.
  always_ff @(posedge clk) begin
    if (rst_n && push) stk[depth] <= ret_addr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      depth <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
      flush <= 1'b0;
    end else begin
      flush <= pc_we;
      if (push)     depth <= depth + 4'd1;
      else if (pop) depth <= depth - 4'd1;
      // Set wins over a same-cycle clear.
      ovf <= ovf_ev | (ovf & ~clr_err);
      unf <= unf_ev | (unf & ~clr_err);
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] pc_cur, target;
  logic       jmp, br, cond, call, ret, clr_err;
  logic [5:0] pc_next;
  logic       pc_we, flush, ovf, unf;
  logic [3:0] depth;

  branch_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pc_cur(pc_cur), .jmp(jmp), .br(br), .cond(cond),
    .call(call), .ret(ret), .target(target), .clr_err(clr_err),
    .pc_next(pc_next), .pc_we(pc_we), .flush(flush), .depth(depth),
    .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] nx;
    logic       we;
    logic       chk_nx;
    logic       fl;
    int         dp;
    logic       ov;
    logic       un;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   nchk = 0;
  int   npass = 0;

  // Reference model state
  int   mstk[$];
  logic m_ov = 1'b0, m_un = 1'b0, m_fl = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    nchk++;
    if (act == req) npass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
  endtask

  // Monitor: every negedge the DUT presents a full set of outputs.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pc_we", int'(pc_we), int'(e.we));
      if (e.chk_nx) chk("pc_next", int'(pc_next), int'(e.nx));
      chk("flush", int'(flush), int'(e.fl));
      chk("depth", int'(depth), e.dp);
      chk("ovf",   int'(ovf),   int'(e.ov));
      chk("unf",   int'(unf),   int'(e.un));
    end
  end

  // Drive one cycle of inputs, predict outputs, advance the model past the edge.
  task automatic cyc(input logic r, input logic j, input logic b, input logic c,
                     input logic ca, input logic rt, input int tg,
                     input logic clr, input int pc);
    exp_t x;
    rst_n = r; jmp = j; br = b; cond = c; call = ca; ret = rt;
    target = 6'(tg); clr_err = clr; pc_cur = 6'(pc);
    x.chk_nx = 1'b1;
    x.nx = '0;
    x.we = 1'b0;
    if (rt) begin
      if (mstk.size() > 0) begin x.we = 1'b1; x.nx = 6'(mstk[$]); end
    end else if (ca || j) begin
      x.we = 1'b1; x.nx = 6'(tg);
    end else if (b) begin
      if (c) begin x.we = 1'b1; x.nx = 6'(tg); end
      else x.chk_nx = 1'b0;
    end
    x.fl = m_fl; x.dp = mstk.size(); x.ov = m_ov; x.un = m_un;
    q.push_back(x);
    if (!r) begin
      mstk.delete(); m_ov = 1'b0; m_un = 1'b0; m_fl = 1'b0;
    end else begin
      logic oe, ue;
      oe = 1'b0; ue = 1'b0;
      m_fl = x.we;
      if (rt) begin
        if (mstk.size() > 0) void'(mstk.pop_back());
        else ue = 1'b1;
      end else if (ca) begin
        if (mstk.size() < DEPTH) mstk.push_back((pc + 1) % 64);
        else oe = 1'b1;
      end
      m_ov = oe || (m_ov && !clr);
      m_un = ue || (m_un && !clr);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int pc);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; jmp = 0; br = 0; cond = 0; call = 0; ret = 0;
    target = 0; clr_err = 0; pc_cur = 0;
    @(posedge clk); #1;
    // Reset
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0); idle(1);
    // Call/return with wrap
    cyc(1, 0, 0, 0, 1, 0, 10, 0, 63);
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 10);
    idle(0); idle(1);
    // Conditional branch
    cyc(1, 0, 1, 0, 0, 0, 20, 0, 2);
    cyc(1, 0, 1, 1, 0, 0, 20, 0, 3);
    idle(20); idle(21);
    // Overflow: 9 calls then 8 rets
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0, 1, 0, 40 + i, 0, i);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 0, 1, 0, 0, 30);
    idle(1);
    // Underflow and clear
    cyc(1, 0, 0, 0, 0, 1, 0, 1, 5);
    idle(5);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 5);
    idle(5);
    cyc(1, 0, 0, 0, 0, 1, 0, 1, 5);
    idle(5);
    // Reset mid-sequence discards the stack
    cyc(1, 0, 0, 0, 1, 0, 12, 1, 4);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 12);
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
    // Priority: call+ret at depth 1 with top 5; jmp+br cond=0
    cyc(1, 0, 0, 0, 1, 0, 33, 0, 4);
    cyc(1, 0, 0, 0, 1, 1, 50, 0, 33);
    cyc(1, 1, 1, 0, 0, 0, 7, 0, 5);
    idle(7);
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int  rnd;
      logic r;
      rnd = int'($urandom_range(0, 99));
      r = ($urandom_range(0, 99) != 0);
      cyc(r,
          rnd >= 60 && rnd < 70,
          (rnd >= 70 && rnd < 85) || ($urandom_range(0, 3) == 0),
          1'($urandom),
          rnd >= 30 && rnd < 60,
          rnd < 30,
          int'($urandom_range(0, 63)),
          ($urandom_range(0, 9) == 0),
          int'($urandom_range(0, 63)));
    end
    idle(0);
    repeat (2) @(posedge clk);
    #1;
    nchk++;
    if (q.size() == 0) npass++;
    else $display("FAIL drain: got %0d pending expected 0", q.size());
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Next-PC control for the 6-bit program counter. Decides each cycle whether the PC loads a redirect target or keeps incrementing, and drives the PC's `pc_in`/`we` pair. Handles jumps, conditional branches, and call/return through an internal return-address stack. Emits a one-cycle flush to the decoder after every redirect.

## Interface
- DEPTH, 8: return-stack entries; legal range 1..15.
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- pc_cur  in  6  current PC value (PC output)
- jmp  in  1  unconditional jump to `target`
- br  in  1  conditional branch to `target`, taken when `cond`=1
- cond  in  1  branch condition (e.g. zero flag)
- call  in  1  push return address, jump to `target`
- ret  in  1  pop return address, jump to it
- target  in  6  jump/branch/call destination
- clr_err  in  1  clears sticky error flags
- pc_next  out  6  value for PC `pc_in`
- pc_we  out  1  PC load enable
- flush  out  1  kill instruction currently in decode
- depth  out  4  current stack occupancy, 0..DEPTH
- ovf  out  1  sticky: call attempted with stack full
- unf  out  1  sticky: ret attempted with stack empty

## Operation
- Request priority when several are high: ret > call > jmp > br. Lower-priority requests in the same cycle are ignored entirely.
- Return address = pc_cur + 1, modulo 64 (63 wraps to 0).
- **ret, depth>0:**
  - pc_next = top entry, pc_we=1.
  - At the clock edge, depth decrements.
- **ret, depth=0:**
  - pc_we=0, pc_next=0.
  - unf sets at the clock edge.
  - Stack unchanged.
- **call, depth<DEPTH:**
  - pc_next=target, pc_we=1.
  - At the clock edge, the return address is written at index depth and depth increments.
- **call, depth=DEPTH:**
  - pc_next=target, pc_we=1.
  - No push; ovf sets at the clock edge.
  - Oldest entries are preserved.
- **jmp:** pc_next=target, pc_we=1.
- **br with cond=1:** pc_next=target, pc_we=1.
- **br with cond=0:** pc_we=0.
- **No request:** pc_we=0, pc_next=0.
- "Redirect" means any cycle with pc_we=1.
- flush is registered and equals the pc_we of the previous cycle.
- Sticky flags:
  - ovf and unf hold until reset or clr_err.
  - If clr_err and a new error event occur in the same cycle, the flag ends set: set wins.
- Stack storage needs no reset. Only depth is reset; entries at index ≥ depth are never read.

## Timing
- pc_next and pc_we are combinational from the inputs, pc_cur, and stack state, so the PC samples them at the same edge.
- No latency is added to a redirect. The PC holds the target one edge after the request.
- flush is high for exactly the one cycle following a redirect cycle. Back-to-back redirects give a continuous flush.
- On reset (rst_n=0 at a posedge):
  - depth=0, ovf=0, unf=0, flush=0.
  - pc_we and pc_next depend on inputs only. With all requests low they are 0.
  - Stack pushes and pops are suppressed while rst_n=0.
- Reset mid-sequence discards all stack contents: a following ret underflows.
- Call immediately followed by ret in the next cycle returns the address pushed by that call.

## Test plan
- **Reset:**
  - Stimulus: hold rst_n=0 two cycles, then release with no requests.
  - Required response: depth=0, ovf=0, unf=0, flush=0, pc_we=0 on every cycle.
- **Call/return with wrap:**
  - Stimulus: pc_cur=63, call target=10; next cycle, ret.
  - Required response:
    - Call cycle: pc_next=10, pc_we=1, depth 0→1.
    - Ret cycle: pc_next=0, depth 1→0.
    - flush high on both following cycles.
- **Conditional branch:**
  - Stimulus: br target=20 with cond=0, then br target=20 with cond=1.
  - Required response: first pc_we=0; second pc_next=20, pc_we=1; flush=1 in the next cycle only.
- **Overflow:**
  - Stimulus: 9 calls with DEPTH=8 from pc_cur=0..8; then 8 rets.
  - Required response:
    - 9th call still redirects, depth stays 8, ovf=1.
    - Rets return 8,7,…,1.
- **Underflow and clear:**
  - Stimulus: ret at depth=0; then pulse clr_err.
  - Required response: pc_we=0, unf=1; unf=0 after clr_err.
  - Stimulus: clr_err together with a ret at depth=0.
  - Required response: unf=1.
- **Priority:**
  - Stimulus: call+ret at depth=1 with top entry 5.
  - Required response: pc_next=5, depth→0, no push.
  - Stimulus: jmp+br, target=7, cond=0.
  - Required response: pc_next=7, pc_we=1.
